// File: rtl/serial_neg_pkg.sv
// Shared types for the bit-serial negate array: mode encoding and framing state.
package serial_neg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS     = 2'b00,
    MODE_NEG      = 2'b01,
    MODE_ABS      = 2'b10,
    MODE_PASS_ALT = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/serial_negate_array_if.sv
// Serial word bus: LSB-first input bits with framing, processed output bits with status pulses.
interface serial_negate_array_if
  import serial_neg_pkg::*;
#(
  parameter int CHANNELS = 2
);

  logic                start;
  logic                in_valid;
  logic [CHANNELS-1:0] din;
  logic [MODE_W-1:0]   mode;
  logic [CHANNELS-1:0] dout;
  logic                out_valid;
  logic                out_sof;
  logic [CHANNELS-1:0] overflow;
  logic                frame_err;

  modport master (
    output start, in_valid, din, mode,
    input  dout, out_valid, out_sof, overflow, frame_err
  );

  modport slave (
    input  start, in_valid, din, mode,
    output dout, out_valid, out_sof, overflow, frame_err
  );

endinterface

// File: rtl/serial_neg_lane.sv
// One serial lane: pass/negate/abs with most-negative detect; latency 1, or WIDTH+1 with
// SERIAL_NEG_ABS_EN (delay line lets the MSB pick the sign). No backpressure.
module serial_neg_lane
  import serial_neg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld_i,
  input  logic             first_i,
  input  logic             last_i,
  input  mode_e            mode_i,
  input  logic             din_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] abort_len_i,
  output logic             dout_o,
  output logic             ovf_o,
  output logic             tap_vld_o,
  output logic             tap_sof_o
);

  logic p_vld, p_first, p_last, p_din, neg_first;
  logic seen_q, zero_q, neg_q, dout_q, ovf_q;
  logic seen_cur, zero_cur, neg_cur;

`ifdef SERIAL_NEG_ABS_EN
  typedef struct packed {
    logic  vld;
    logic  sof;
    logic  last;
    mode_e mode;
    logic  dat;
  } stage_t;

  stage_t line_q [WIDTH];
  stage_t line_d [WIDTH];

  // Aborted word occupies the youngest abort_len stages; drop their valid tags.
  always_comb begin
    line_d[0] = '{vld: bit_vld_i, sof: first_i, last: last_i, mode: mode_i, dat: din_i};
    for (int i = 1; i < WIDTH; i++) begin
      line_d[i] = line_q[i-1];
      if (abort_i && ((i - 1) < int'(abort_len_i))) line_d[i].vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) line_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) line_q[i] <= line_d[i];
    end
  end

  // When bit 0 reaches the exit, the same word's MSB sits in stage 0.
  assign p_vld     = line_q[WIDTH-1].vld;
  assign p_first   = line_q[WIDTH-1].sof;
  assign p_last    = line_q[WIDTH-1].last;
  assign p_din     = line_q[WIDTH-1].dat;
  assign neg_first = (line_q[WIDTH-1].mode == MODE_NEG) ||
                     ((line_q[WIDTH-1].mode == MODE_ABS) && line_q[0].dat);
`else
  logic unused_abort;
  assign unused_abort = ^{abort_i, abort_len_i};

  assign p_vld     = bit_vld_i;
  assign p_first   = first_i;
  assign p_last    = last_i;
  assign p_din     = din_i;
  assign neg_first = (mode_i == MODE_NEG);
`endif

  assign seen_cur = p_first ? 1'b0 : seen_q;
  assign zero_cur = p_first ? 1'b1 : zero_q;
  assign neg_cur  = p_first ? neg_first : neg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
      dout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= p_vld & (p_din ^ (neg_cur & seen_cur));
      ovf_q  <= p_vld & p_last & neg_cur & zero_cur & p_din;
      if (p_vld) begin
        seen_q <= seen_cur | p_din;
        zero_q <= zero_cur & ~p_din;
        neg_q  <= neg_cur;
      end
    end
  end

  assign dout_o    = dout_q;
  assign ovf_o     = ovf_q;
  assign tap_vld_o = p_vld;
  assign tap_sof_o = p_vld & p_first;

endmodule

// File: rtl/serial_negate_array.sv
// CHANNELS lock-step serial negate lanes sharing one framing counter; latency 1 (WIDTH+1 with
// SERIAL_NEG_ABS_EN). No backpressure: in_valid must hold for a whole word, violations pulse frame_err.
module serial_negate_array
  import serial_neg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_negate_array_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  mode_e               mode_q, mode_d, mode_eff;
  logic                acc, first, last, abort, err_d, err_q;
  logic                out_valid_q, out_sof_q;
  logic [CHANNELS-1:0] tap_vld, tap_sof, dout_w, ovf_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_PASS;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      out_valid_q <= &tap_vld;
      out_sof_q   <= &tap_sof;
    end
  end

  // cnt_q is the index of the next expected bit, so it also counts bits taken so far.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    acc      = 1'b0;
    first    = 1'b0;
    last     = 1'b0;
    abort    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && bus.start) begin
          acc     = 1'b1;
          first   = 1'b1;
          cnt_d   = CNT_W'(1);
          mode_d  = mode_e'(bus.mode);
          state_d = ST_BUSY;
        end else if (bus.in_valid) begin
          err_d = 1'b1;
        end
      end
      default: begin
        if (!bus.in_valid) begin
          err_d   = 1'b1;
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.start) begin
          err_d  = 1'b1;
          abort  = 1'b1;
          acc    = 1'b1;
          first  = 1'b1;
          cnt_d  = CNT_W'(1);
          mode_d = mode_e'(bus.mode);
        end else begin
          acc = 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            last    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    mode_eff = first ? mode_e'(bus.mode) : mode_q;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    serial_neg_lane #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_vld_i   (acc),
      .first_i     (first),
      .last_i      (last),
      .mode_i      (mode_eff),
      .din_i       (bus.din[g]),
      .abort_i     (abort),
      .abort_len_i (cnt_q),
      .dout_o      (dout_w[g]),
      .ovf_o       (ovf_w[g]),
      .tap_vld_o   (tap_vld[g]),
      .tap_sof_o   (tap_sof[g])
    );
  end

  assign bus.dout      = dout_w;
  assign bus.overflow  = ovf_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_serial_negate_array.sv
// Directed bench for serial_negate_array (WIDTH=8, CHANNELS=2); outputs logged per cycle, words rebuilt.
module tb_serial_negate_array;

`ifdef SERIAL_NEG_ABS_EN
  localparam int LAT = 9;
  localparam bit ABS = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit ABS = 1'b0;
`endif
  localparam int NLOG = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  serial_negate_array_if #(.CHANNELS(2)) bus ();

  serial_negate_array #(.WIDTH(8), .CHANNELS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] lg_dout [NLOG];
  logic [1:0] lg_ovf  [NLOG];
  logic       lg_vld  [NLOG];
  logic       lg_sof  [NLOG];
  logic       lg_err  [NLOG];

  always @(negedge clk) begin
    if (cyc < NLOG) begin
      lg_dout[cyc] = bus.dout;
      lg_ovf[cyc]  = bus.overflow;
      lg_vld[cyc]  = bus.out_valid;
      lg_sof[cyc]  = bus.out_sof;
      lg_err[cyc]  = bus.frame_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic vld, input logic [1:0] d, input logic [1:0] md);
    bus.start    = st;
    bus.in_valid = vld;
    bus.din      = d;
    bus.mode     = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input logic [1:0] md,
                           output int s);
    s = cyc;
    for (int k = 0; k < 8; k++) drive(k == 0, 1'b1, {w1[k], w0[k]}, md);
  endtask

  function automatic logic [7:0] word_of(input int ch, input int base);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[k] = lg_dout[base+k][ch];
    return w;
  endfunction

  function automatic logic [7:0] ovf_of(input int ch, input int base);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[k] = lg_ovf[base+k][ch];
    return w;
  endfunction

  // sel: 0 out_valid, 1 out_sof, 2 frame_err, 3 any overflow
  function automatic int cnt_of(input int sel, input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) begin
      case (sel)
        0:       n += int'(lg_vld[c]);
        1:       n += int'(lg_sof[c]);
        2:       n += int'(lg_err[c]);
        default: n += int'(|lg_ovf[c]);
      endcase
    end
    return n;
  endfunction

  initial begin
    int s, s2, a, r;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.din = '0; bus.mode = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    idle(2);
    chk("rst_vld",  32'(lg_vld[r]),  32'd0);
    chk("rst_sof",  32'(lg_sof[r]),  32'd0);
    chk("rst_dout", 32'(lg_dout[r]), 32'd0);
    chk("rst_ovf",  32'(lg_ovf[r]),  32'd0);
    chk("rst_err",  32'(lg_err[r]),  32'd0);

    // 1: negate 0x05 -> 0xFB
    send_word(8'h05, 8'h00, 2'b01, s);
    idle(LAT + 2);
    chk("t1_ch0",     32'(word_of(0, s + LAT)), 32'hFB);
    chk("t1_ch1",     32'(word_of(1, s + LAT)), 32'h00);
    chk("t1_lat_pre", 32'(lg_vld[s + LAT - 1]), 32'd0);
    chk("t1_vld",     32'(cnt_of(0, s + LAT, s + LAT + 7)), 32'd8);
    chk("t1_sof",     32'(lg_sof[s + LAT]), 32'd1);
    chk("t1_sof_cnt", 32'(cnt_of(1, s + LAT, s + LAT + 7)), 32'd1);
    chk("t1_ovf",     32'(cnt_of(3, s + LAT, s + LAT + 7)), 32'd0);

    // 2: negate most-negative on ch1, zero on ch0
    send_word(8'h00, 8'h80, 2'b01, s);
    idle(LAT + 2);
    chk("t2_ch1",  32'(word_of(1, s + LAT)), 32'h80);
    chk("t2_ch0",  32'(word_of(0, s + LAT)), 32'h00);
    chk("t2_ovf1", 32'(ovf_of(1, s + LAT)),  32'h80);
    chk("t2_ovf0", 32'(ovf_of(0, s + LAT)),  32'h00);

    // 3: back-to-back negate 0x01, 0x7F
    send_word(8'h01, 8'h00, 2'b01, s);
    send_word(8'h7F, 8'h00, 2'b01, s2);
    idle(LAT + 2);
    chk("t3_w0",   32'(word_of(0, s + LAT)),  32'hFF);
    chk("t3_w1",   32'(word_of(0, s2 + LAT)), 32'h81);
    chk("t3_vld",  32'(cnt_of(0, s + LAT, s + LAT + 15)), 32'd16);
    chk("t3_sof2", 32'(lg_sof[s + LAT + 8]), 32'd1);
    chk("t3_err",  32'(cnt_of(2, s, s + LAT + 16)), 32'd0);

    // 4: start again at bit 3; new word 0x03 / 0x80 negate
    s = cyc;
    for (int k = 0; k < 3; k++) drive(k == 0, 1'b1, 2'b01, 2'b01);
    a = cyc;
    send_word(8'h03, 8'h80, 2'b01, s2);
    idle(LAT + 2);
    chk("t4_err_pre", 32'(lg_err[a]),     32'd0);
    chk("t4_err",     32'(lg_err[a + 1]), 32'd1);
    chk("t4_err_1",   32'(lg_err[a + 2]), 32'd0);
    chk("t4_ch0",     32'(word_of(0, a + LAT)), 32'hFD);
    chk("t4_ch1",     32'(word_of(1, a + LAT)), 32'h80);
    chk("t4_ovf1",    32'(ovf_of(1, a + LAT)),  32'h80);
    chk("t4_ovf_cnt", 32'(cnt_of(3, s + LAT, a + LAT + 7)), 32'd1);
    chk("t4_vld",     32'(cnt_of(0, s + LAT, a + LAT + 7)), ABS ? 32'd8 : 32'd11);
    chk("t4_sof",     32'(cnt_of(1, s + LAT, a + LAT + 7)), ABS ? 32'd1 : 32'd2);

    // 5: abs mode 0xFA / 0x06
    send_word(8'hFA, 8'h06, 2'b10, s);
    idle(LAT + 2);
    chk("t5_ch0", 32'(word_of(0, s + LAT)), ABS ? 32'h06 : 32'hFA);
    chk("t5_ch1", 32'(word_of(1, s + LAT)), 32'h06);
    chk("t5_pre", 32'(lg_vld[s + LAT - 1]), 32'd0);
    chk("t5_sof", 32'(lg_sof[s + LAT]),     32'd1);

    // 6: reset at bit 4, tail bits without start ignored, then a clean word
    s = cyc;
    for (int k = 0; k < 4; k++) drive(k == 0, 1'b1, {1'b0, k == 0 || k == 2}, 2'b01);
    r = cyc;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 2'b01);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 2'b00, 2'b01);
    idle(LAT + 2);
    chk("t6_rst_vld",  32'(lg_vld[r + 1]),  32'd0);
    chk("t6_rst_dout", 32'(lg_dout[r + 1]), 32'd0);
    chk("t6_rst_err",  32'(lg_err[r + 1]),  32'd0);
    chk("t6_rst_ovf",  32'(lg_ovf[r + 1]),  32'd0);
    chk("t6_quiet",    32'(cnt_of(0, r + 1, r + LAT + 5)), 32'd0);
    chk("t6_ign_err",  32'(cnt_of(2, r + 2, r + 4)), 32'd3);
    send_word(8'h05, 8'h00, 2'b01, s);
    idle(LAT + 2);
    chk("t6_word", 32'(word_of(0, s + LAT)), 32'hFB);
    chk("t6_vld",  32'(cnt_of(0, s + LAT, s + LAT + 7)), 32'd8);

    // 7: pass modes 00 and 11 back-to-back; 0x80 passed gives no overflow
    send_word(8'h5A, 8'h00, 2'b00, s);
    send_word(8'h80, 8'h00, 2'b11, s2);
    idle(LAT + 2);
    chk("t7_w0",  32'(word_of(0, s + LAT)),  32'h5A);
    chk("t7_w1",  32'(word_of(0, s2 + LAT)), 32'h80);
    chk("t7_ovf", 32'(cnt_of(3, s + LAT, s2 + LAT + 7)), 32'd0);

    // 8: in_valid drops mid-word
    s = cyc;
    for (int k = 0; k < 3; k++) drive(k == 0, 1'b1, 2'b11, 2'b01);
    a = cyc;
    idle(LAT + 12);
    chk("t8_err", 32'(lg_err[a + 1]), 32'd1);
    chk("t8_vld", 32'(cnt_of(0, s + LAT, s + LAT + 10)), ABS ? 32'd0 : 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_negate_array.md
# serial_negate_array

Parametrised bit-serial two's-complement unit, successor to the single-bit serial inverter. Processes `CHANNELS` independent LSB-first serial words of `WIDTH` bits in lock-step, sharing one framing counter. Per word it passes, negates or (optionally) takes the absolute value of each channel. It flags most-negative overflow and framing errors. It sits between the serial source and downstream serial arithmetic.

## Interface
- `WIDTH`, 8: bits per serial word (≥ 2).
- `CHANNELS`, 2: number of parallel serial lanes (≥ 1).

- `clk`  in  1  rising-edge clock; all state updates on it.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  marks bit 0 (LSB) of a word; only meaningful with `in_valid`.
- `in_valid`  in  1  input bit qualifier; must stay high for all `WIDTH` bits of a word.
- `din`  in  CHANNELS  one serial bit per channel.
- `mode`  in  2  00 pass, 01 negate, 10 abs, 11 pass; sampled with `start`.
- `dout`  out  CHANNELS  processed serial bits, LSB first.
- `out_valid`  out  1  `dout` qualifier.
- `out_sof`  out  1  high with bit 0 of each output word.
- `overflow`  out  CHANNELS  one-cycle pulse with the MSB output bit when that channel negated the most-negative value.
- `frame_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- The bit counter runs 0..`WIDTH`-1 on accepted bits. `start`&`in_valid` loads 0 and latches `mode`. The counter wraps to idle after bit `WIDTH`-1.
- Back-to-back words: `start` on the cycle after bit `WIDTH`-1 is legal and has no gap.
- Negate per lane: a `seen_one` flag clears at bit 0. Each output bit = input bit XOR `seen_one`. `seen_one` is set after any input 1.
- Pass: output = input.
- Overflow: input bits 0..`WIDTH`-2 all 0 and MSB 1, with negation applied. Output bits are unchanged (value wraps to itself). Pulse on the MSB output cycle. An all-zero word gives no overflow.
- Framing violations, all reported by `frame_err` and suppressing `overflow` for the aborted word:
  - `start` mid-word aborts the current word. The `start` bit begins a new word.
  - `in_valid` low mid-word aborts; the counter goes idle.
  - `in_valid` without `start` while idle: the bit is ignored.
- Reset values: `dout`=0, `out_valid`=0, `out_sof`=0, `overflow`=0, `frame_err`=0. Counter idle, `seen_one`=0, latched mode=pass, delay-line valid tags cleared.
- Reset mid-word discards the word. Next accepted word requires `start`.

## Timing
- Without `ABS_EN`: latency 1 cycle. Input bit k at cycle t appears on `dout` at t+1.
- With `ABS_EN`: latency `WIDTH`+1 for all modes, so timing is mode-independent. The sign is known when bit `WIDTH`-1 enters, which is exactly when bit 0 exits the delay line.
- `frame_err` is registered: it asserts 1 cycle after the violating input cycle.
- Output bits already emitted before an abort stay emitted (no ABS_EN).

## Configuration
- `SERIAL_NEG_ABS_EN` defined:
  - Per-lane `WIDTH`-deep delay line with per-stage valid tags.
  - Mode 10 negates iff the word's MSB is 1; overflow is as for negate.
  - Abort clears the valid tags of the aborted word, so no `out_valid` is produced for it.
- Not defined:
  - No delay line; mode 10 behaves as pass.
  - Latency 1.

## Structure
- Package `serial_neg_pkg`: mode enum (`MODE_PASS`, `MODE_NEG`, `MODE_ABS`) and 2-bit mode width constant.
- Sub-module `serial_neg_lane`: one channel. Holds `seen_one`, overflow detect and the optional delay line.
- The top level instantiates `CHANNELS` lanes and owns the counter, framing, `out_valid` and `out_sof`.

## Test plan
Benches use WIDTH=8, CHANNELS=2.
1. Negate ch0=0x05 (LSB-first 1,0,1,0,0,0,0,0) → `dout`[0] 1,1,0,1,1,1,1,1 (0xFB), `out_sof` on first bit, latency 1 (or 9 with ABS_EN).
2. Negate ch1=0x80, ch0=0x00 → ch1 out 0x80 with `overflow`[1] pulse on the MSB cycle; ch0 out 0x00 with no overflow.
3. Two back-to-back words (0x01 then 0x7F, negate) → 0xFF then 0x81; `out_valid` continuous for 16 cycles.
4. `start` reasserted at bit 3 → `frame_err` one cycle later; the new word processes correctly; no overflow for the aborted word.
5. ABS_EN, mode abs, ch0=0xFA, ch1=0x06 → both output 0x06, first output bit 9 cycles after `start`.
6. `rst_n` low at bit 4 for one cycle → all outputs 0. Bits without `start` are ignored; the next `start` word is correct.
